mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-port synchronous RAM between the pipeline's instruction-fetch (IF) requester and its data-access (MEM) requester. It grants one requester at a time, holds the RAM for a fixed number of wait cycles, and returns a one-cycle ready pulse with registered read data. It also generates the per-port stall signals that freeze the PC/IF-ID register or the MEM stage. It sits between the pipeline stages and the unified memory.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_perf.sv | 25 ++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: arbiter states,
// requester identifiers and the legal range of the RAM wait-cycle count.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2
    } arb_state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    // Keeps the wait count inside what the 4-bit occupancy counter can hold.
    function automatic int clamp_wait(input int w);
        if (w < WAIT_MIN)
            return WAIT_MIN;
        else if (w > WAIT_MAX)
            return WAIT_MAX;
        else
            return w;
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating stall-cycle counters for the two requesters of mem_port_arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        stall_mem,
    output logic [31:0] perf_if_wait,
    output logic [31:0] perf_mem_wait
);

    // Count every cycle each port is stalled, sticking at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_if_wait  <= '0;
            perf_mem_wait <= '0;
        end else begin
            if (stall_if && (perf_if_wait != '1))
                perf_if_wait <= perf_if_wait + 32'd1;
            if (stall_mem && (perf_mem_wait != '1))
                perf_mem_wait <= perf_mem_wait + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the IF and MEM requesters.
// MEM always wins over IF, each access occupies the RAM for WAIT_CYCLES
// cycles and finishes with a one-cycle ready pulse plus registered data.
// Optional MEM_ARB_PERF_EN adds saturating stall-cycle counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_mem_wait
`endif
);

    localparam int         WAIT_EFF = clamp_wait(WAIT_CYCLES);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_EFF - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              ram_en_nxt;
    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic              if_ready_nxt;
    logic              mem_ready_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic [DATA_W-1:0] mem_rdata_nxt;
    logic              if_elig;
    logic              mem_elig;
    logic              done_id;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

    // A port whose ready is pulsing this cycle has just been served and must
    // not be granted again on the same edge.
    assign if_elig  = if_req & ~if_ready;
    assign mem_elig = mem_req & ~mem_ready;
    assign done_id  = (state == ARB_BUSY_MEM) ? REQ_MEM : REQ_IF;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Grant, occupancy countdown and completion decisions.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ram_en_nxt    = ram_en;
        ram_we_nxt    = ram_we;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        if_ready_nxt  = 1'b0;
        mem_ready_nxt = 1'b0;
        if_rdata_nxt  = if_rdata;
        mem_rdata_nxt = mem_rdata;
        case (state)
            ARB_IDLE: begin
                if (mem_elig) begin
                    state_nxt     = ARB_BUSY_MEM;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = mem_we;
                    ram_addr_nxt  = mem_addr;
                    ram_wdata_nxt = mem_wdata;
                    cnt_nxt       = CNT_LOAD;
                end else if (if_elig) begin
                    state_nxt     = ARB_BUSY_IF;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = 1'b0;
                    ram_addr_nxt  = if_addr;
                    ram_wdata_nxt = '0;
                    cnt_nxt       = CNT_LOAD;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt  = ARB_IDLE;
                    ram_en_nxt = 1'b0;
                    ram_we_nxt = 1'b0;
                    if (done_id == REQ_MEM) begin
                        mem_ready_nxt = 1'b1;
                        if (!ram_we)
                            mem_rdata_nxt = ram_rdata;
                    end else begin
                        if_ready_nxt = 1'b1;
                        if_rdata_nxt = ram_rdata;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Registered RAM command, counter, ready pulses and read-data holding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            cnt       <= cnt_nxt;
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            if_ready  <= if_ready_nxt;
            mem_ready <= mem_ready_nxt;
            if_rdata  <= if_rdata_nxt;
            mem_rdata <= mem_rdata_nxt;
        end
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clock         (clock),
        .reset         (reset),
        .stall_if      (stall_if),
        .stall_mem     (stall_mem),
        .perf_if_wait  (perf_if_wait),
        .perf_mem_wait (perf_mem_wait)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with WAIT_CYCLES=1 and
// one with WAIT_CYCLES=3, each backed by a small behavioural RAM.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int P_IF1  = 0;
    localparam int P_MEM1 = 1;
    localparam int P_MEM3 = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clock;
    logic reset;

    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_ready, mem_ready;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        stall_if, stall_mem;

    logic        if_req_w3, mem_req_w3, mem_we_w3;
    logic [31:0] if_addr_w3, mem_addr_w3, mem_wdata_w3;
    logic [31:0] if_rdata_w3, mem_rdata_w3;
    logic        if_ready_w3, mem_ready_w3;
    logic        ram_en_w3, ram_we_w3;
    logic [31:0] ram_addr_w3, ram_wdata_w3, ram_rdata_w3;
    logic        stall_if_w3, stall_mem_w3;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_wait, perf_mem_wait;
    logic [31:0] perf_if_wait_w3, perf_mem_wait_w3;
`endif

    int   cyc = 0;
    int   testCount = 0;
    int   failCount = 0;
    exp_t if1_q[$];
    exp_t mem1_q[$];
    exp_t mem3_q[$];

    logic [31:0] ram3 [0:255];
    logic        ram3_loaded = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_wait(perf_if_wait), .perf_mem_wait(perf_mem_wait)
`endif
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(if_req_w3), .if_addr(if_addr_w3), .if_rdata(if_rdata_w3), .if_ready(if_ready_w3),
        .mem_req(mem_req_w3), .mem_we(mem_we_w3), .mem_addr(mem_addr_w3), .mem_wdata(mem_wdata_w3),
        .mem_rdata(mem_rdata_w3), .mem_ready(mem_ready_w3),
        .ram_en(ram_en_w3), .ram_we(ram_we_w3), .ram_addr(ram_addr_w3), .ram_wdata(ram_wdata_w3),
        .ram_rdata(ram_rdata_w3), .stall_if(stall_if_w3), .stall_mem(stall_mem_w3)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_wait(perf_if_wait_w3), .perf_mem_wait(perf_mem_wait_w3)
`endif
    );

    // Read-only contents of the RAM behind the WAIT_CYCLES=1 instance.
    function automatic logic [31:0] init1(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2001_0005;
            32'h0000_0044: return 32'h2001_0011;
            32'h0000_0080: return 32'h3000_0080;
            default:       return 32'hA000_0000 | (a >> 2);
        endcase
    endfunction

    function automatic logic [31:0] init3(input int k);
        case (k)
            32'h41:  return 32'h1234_5678;
            32'h42:  return 32'hCAFE_0042;
            default: return 32'hB000_0000 | k;
        endcase
    endfunction

    assign ram_rdata    = ram_en ? init1(ram_addr) : 32'h0;
    assign ram_rdata_w3 = ram_en_w3 ? ram3[ram_addr_w3[9:2]] : 32'h0;

    // Writable RAM behind the WAIT_CYCLES=3 instance; loaded on the first edge.
    always @(posedge clock) begin
        if (!ram3_loaded) begin
            for (int k = 0; k < 256; k++)
                ram3[k] <= init3(k);
            ram3_loaded <= 1'b1;
        end else if (ram_en_w3 && ram_we_w3) begin
            ram3[ram_addr_w3[9:2]] <= ram_wdata_w3;
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        testCount++;
        failCount++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Raise a request, queue its expected result, and wait for its ready.
    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_data,
                                 input int exp_off, output int lat);
        int   c0;
        logic got;
        exp_t e;
        @(posedge clock);
        #1;
        c0 = cyc;
        e.data = exp_data;
        e.cyc  = (exp_off < 0) ? -1 : c0 + exp_off;
        case (port)
            P_IF1:   begin if_addr = addr; if_req = 1'b1; if1_q.push_back(e); end
            P_MEM1:  begin mem_we = we; mem_addr = addr; mem_wdata = wdata;
                           mem_req = 1'b1; mem1_q.push_back(e); end
            default: begin mem_we_w3 = we; mem_addr_w3 = addr; mem_wdata_w3 = wdata;
                           mem_req_w3 = 1'b1; mem3_q.push_back(e); end
        endcase
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clock);
            case (port)
                P_IF1:   got = if_ready;
                P_MEM1:  got = mem_ready;
                default: got = mem_ready_w3;
            endcase
        end
        if (!got)
            failNow($sformatf("ready_timeout_port%0d", port));
        lat = cyc - c0;
    endtask

    task automatic releaseReq(input int port);
        @(posedge clock);
        #1;
        case (port)
            P_IF1:   if_req = 1'b0;
            P_MEM1:  mem_req = 1'b0;
            default: mem_req_w3 = 1'b0;
        endcase
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (if_ready) begin
            if (if1_q.size() == 0) failNow("if1_unexpected_ready");
            else begin
                e = if1_q.pop_front();
                checkOutput("if1_rdata", if_rdata, e.data);
                if (e.cyc >= 0) checkOutput("if1_ready_cycle", cyc, e.cyc);
            end
        end
        if (mem_ready) begin
            if (mem1_q.size() == 0) failNow("mem1_unexpected_ready");
            else begin
                e = mem1_q.pop_front();
                checkOutput("mem1_rdata", mem_rdata, e.data);
                if (e.cyc >= 0) checkOutput("mem1_ready_cycle", cyc, e.cyc);
            end
        end
        if (mem_ready_w3) begin
            if (mem3_q.size() == 0) failNow("mem3_unexpected_ready");
            else begin
                e = mem3_q.pop_front();
                checkOutput("mem3_rdata", mem_rdata_w3, e.data);
                if (e.cyc >= 0) checkOutput("mem3_ready_cycle", cyc, e.cyc);
            end
        end
        if (if_ready_w3) failNow("w3_if_unexpected_ready");
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        if_req_w3 = 1'b0; if_addr_w3 = '0;
        mem_req_w3 = 1'b0; mem_we_w3 = 1'b0; mem_addr_w3 = '0; mem_wdata_w3 = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, '0);
        checkOutput("rst_ready", {if_ready, mem_ready, stall_if, stall_mem}, '0);
        checkOutput("rst_rdata", {if_rdata, mem_rdata}, '0);
        checkOutput("rst_state", dut1.state, ARB_IDLE);
        checkOutput("rst_w3_idle", {if_ready_w3, stall_if_w3, if_rdata_w3, ram_en_w3}, '0);
        reset = 1'b0;

        // Lone IF read: ram_en only in cycle 1, ready in cycle 2.
        fork
            applyStimulus(P_IF1, 1'b0, 32'h40, 32'h0, 32'h2001_0005, 2, lat);
            begin
                @(posedge clock);
                @(negedge clock);
                checkOutput("s1_c0_stall_if", stall_if, 1'b1);
                checkOutput("s1_c0_ram_en", ram_en, 1'b0);
                @(negedge clock);
                checkOutput("s1_c1_ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata},
                            {1'b1, 1'b0, 32'h40, 32'h0});
                checkOutput("s1_c1_stall_if", stall_if, 1'b1);
                @(negedge clock);
                checkOutput("s1_c2_ram_en", ram_en, 1'b0);
                checkOutput("s1_c2_stall_if", stall_if, 1'b0);
            end
        join
        releaseReq(P_IF1);

        // Fresh reset so the optional stall counters start from zero.
        @(posedge clock); #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;

        // IF and MEM load together: MEM ready in cycle 2, IF ready in cycle 4.
        fork
            begin
                applyStimulus(P_MEM1, 1'b0, 32'h80, 32'h0, 32'h3000_0080, 2, lat);
                releaseReq(P_MEM1);
            end
            begin
                applyStimulus(P_IF1, 1'b0, 32'h44, 32'h0, 32'h2001_0011, 4, lat);
                releaseReq(P_IF1);
            end
        join
`ifdef MEM_ARB_PERF_EN
        checkOutput("perf_mem_wait", perf_mem_wait, 32'd2);
        checkOutput("perf_if_wait", perf_if_wait, 32'd4);
`endif

        // Continuous IF fetches with MEM loads interleaved every few cycles.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    applyStimulus(P_IF1, 1'b0, 32'h200 + 32'(4 * i), 32'h0,
                                  32'hA000_0080 + 32'(i), -1, lat);
                releaseReq(P_IF1);
            end
            begin
                int mlat;
                for (int j = 0; j < 3; j++) begin
                    repeat (3) @(posedge clock);
                    applyStimulus(P_MEM1, 1'b0, 32'h300 + 32'(4 * j), 32'h0,
                                  32'hA000_00C0 + 32'(j), -1, mlat);
                    checkOutput($sformatf("s5_mem_latency_%0d", j), 32'(mlat <= 3), 32'd1);
                    releaseReq(P_MEM1);
                end
            end
        join

        // WAIT_CYCLES=3: a load to give mem_rdata a known value.
        applyStimulus(P_MEM3, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 4, lat);
        releaseReq(P_MEM3);

        // Store: command stable for cycles 1-3, mem_rdata unchanged at ready.
        fork
            applyStimulus(P_MEM3, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 4, lat);
            begin
                @(posedge clock);
                @(negedge clock);
                checkOutput("s3_c0_ram_en_we", {ram_en_w3, ram_we_w3}, 2'b00);
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clock);
                    checkOutput($sformatf("s3_c%0d_ram_cmd", k),
                                {ram_en_w3, ram_we_w3, stall_mem_w3, ram_addr_w3, ram_wdata_w3},
                                {1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF});
                end
                @(negedge clock);
                checkOutput("s3_c4_ram_en_we", {ram_en_w3, ram_we_w3}, 2'b00);
            end
        join
        releaseReq(P_MEM3);
        applyStimulus(P_MEM3, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, lat);
        releaseReq(P_MEM3);

        // Reset in cycle 2 of a WAIT_CYCLES=3 load, between clock edges.
        @(posedge clock); #1;
        mem_we_w3 = 1'b0; mem_addr_w3 = 32'h108; mem_req_w3 = 1'b1;
        @(posedge clock);
        @(posedge clock); #2;
        checkOutput("s4_pre_ram_en", ram_en_w3, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("s4_rst_ram_cmd", {ram_en_w3, ram_we_w3, ram_addr_w3}, '0);
        checkOutput("s4_rst_ready", mem_ready_w3, 1'b0);
        checkOutput("s4_rst_state", dut3.state, ARB_IDLE);
        checkOutput("s4_rst_rdata", {mem_rdata_w3, if_rdata}, '0);
        #1;
        mem_req_w3 = 1'b0;
        reset = 1'b0;
        applyStimulus(P_MEM3, 1'b0, 32'h108, 32'h0, 32'hCAFE_0042, 4, lat);
        releaseReq(P_MEM3);

        repeat (3) @(posedge clock);
        checkOutput("if1_q_drained", 32'(if1_q.size()), 32'd0);
        checkOutput("mem1_q_drained", 32'(mem1_q.size()), 32'd0);
        checkOutput("mem3_q_drained", 32'(mem3_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
